// File: rtl/nco_sweep_ctrl_if.sv
// nco_sweep_ctrl_if: NCO-side signals driven and observed by the sweep controller.
interface nco_sweep_ctrl_if #(
  parameter int APR = 32,
  parameter int MPR = 16
);
  logic clken;
  logic [APR-1:0] phi_inc;
  logic [MPR-1:0] fsin;
  logic out_valid;
  modport master (output clken, phi_inc, input fsin, out_valid);
  modport slave (input clken, phi_inc, output fsin, out_valid);
endinterface

// File: rtl/nco_sweep_ctrl.sv
// nco_sweep_ctrl: stepped-frequency sweep sequencer that drives an NCO and tags its pipelined samples.
module nco_sweep_ctrl #(
  parameter int APR = 32,
  parameter int MPR = 16,
  parameter int CNTW = 16,
  parameter int NCO_LAT = 12
) (
  input  logic clk,
  input  logic reset_n,
  input  logic start,
  input  logic abort,
  input  logic hold,
  input  logic repeat_en,
  input  logic [APR-1:0] f_start,
  input  logic [APR-1:0] f_step,
  input  logic [CNTW-1:0] n_steps,
  input  logic [CNTW-1:0] dwell,
  nco_sweep_ctrl_if.master nco,
  output logic [MPR-1:0] sample_o,
  output logic sample_valid_o,
  output logic sample_last_o,
  output logic wrap_o,
  output logic busy,
  output logic done
);
  localparam int DW = $clog2(NCO_LAT + 1);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2;
  logic [1:0] state;
  logic [APR-1:0] phi, r_start, r_step;
  logic [CNTW-1:0] r_n, r_dwell, step_cnt, dwell_cnt;
  logic [NCO_LAT-1:0] tag_v, tag_l;
  logic [DW-1:0] drain_cnt;
  logic r_rep, valid_q, last_q, wrap_q, en, run, end_dwell, end_sweep;
  assign busy = state != IDLE;
  assign run = state == RUN;
  assign en = busy && !hold;
  assign end_dwell = dwell_cnt == r_dwell - CNTW'(1);
  assign end_sweep = end_dwell && step_cnt == r_n - CNTW'(1);
  assign nco.clken = en;
  assign nco.phi_inc = phi;
  // Output flags only count in cycles the NCO advances; held registers re-present after a hold.
  assign sample_valid_o = valid_q && en;
  assign sample_last_o = last_q && en;
  assign wrap_o = wrap_q && en;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      phi <= '0;
      r_start <= '0;
      r_step <= '0;
      r_n <= '0;
      r_dwell <= '0;
      r_rep <= 1'b0;
      step_cnt <= '0;
      dwell_cnt <= '0;
      drain_cnt <= '0;
      tag_v <= '0;
      tag_l <= '0;
      sample_o <= '0;
      valid_q <= 1'b0;
      last_q <= 1'b0;
      wrap_q <= 1'b0;
      done <= 1'b0;
    end else if (abort) begin
      state <= IDLE;
      tag_v <= '0;
      tag_l <= '0;
      valid_q <= 1'b0;
      last_q <= 1'b0;
      wrap_q <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (en) begin
        sample_o <= nco.fsin;
        valid_q <= tag_v[NCO_LAT-1] && nco.out_valid;
        last_q <= tag_l[NCO_LAT-1] && nco.out_valid;
        wrap_q <= run && end_sweep && r_rep;
        tag_v <= (tag_v << 1) | NCO_LAT'(run);
        tag_l <= (tag_l << 1) | NCO_LAT'(run && end_sweep && !r_rep);
      end
      if (state == IDLE && start) begin
        if (n_steps != '0 && dwell != '0) begin
          state <= RUN;
          phi <= f_start;
          r_start <= f_start;
          r_step <= f_step;
          r_n <= n_steps;
          r_dwell <= dwell;
          r_rep <= repeat_en;
          step_cnt <= '0;
          dwell_cnt <= '0;
        end else
          done <= 1'b1;
      end
      if (run && en) begin
        dwell_cnt <= end_dwell ? '0 : dwell_cnt + CNTW'(1);
        if (end_dwell && !end_sweep) begin
          phi <= phi + r_step;
          step_cnt <= step_cnt + CNTW'(1);
        end
        if (end_sweep && r_rep) begin
          phi <= r_start;
          step_cnt <= '0;
        end
        if (end_sweep && !r_rep) begin
          state <= DRAIN;
          drain_cnt <= '0;
        end
      end
      // One extra drain cycle lets the final tag pass through the output register.
      if (state == DRAIN && en) begin
        drain_cnt <= drain_cnt + DW'(1);
        if (drain_cnt == DW'(NCO_LAT)) begin
          state <= IDLE;
          done <= 1'b1;
        end
      end
    end
  end
endmodule
